// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - LSU-to-word-memory access sequencer with byte RMW and per-access timeout
module mem_access_ctrl #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic        Req_Write,
    input  logic        Req_Byte,
    input  logic [31:0] Req_Addr,
    input  logic [31:0] Req_Wdata,
    output logic        Resp_Valid,
    output logic        Resp_Error,
    output logic [31:0] Resp_Rdata,
    output logic        Mem_En,
    output logic        Mem_We,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_Wdata,
    input  logic [31:0] Mem_Rdata,
    input  logic        Mem_Ack,
    output logic        Load_Select,
    output logic [1:0]  Offset,
    input  logic [31:0] Load_Data
);

    typedef enum logic [2:0] {IDLE, READ, RMW_RD, RMW_WR, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic        byte_q, byte_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merged_q, merged_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        gap_q, gap_d;
    logic [31:0] merge_w;
    logic        access_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            byte_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            gap_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            byte_q   <= byte_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merged_q <= merged_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
        end
    end

    always_comb begin
        merge_w = Mem_Rdata;
        case (addr_q[1:0])
            2'd0: merge_w[7:0]   = wdata_q[7:0];
            2'd1: merge_w[15:8]  = wdata_q[7:0];
            2'd2: merge_w[23:16] = wdata_q[7:0];
            default: merge_w[31:24] = wdata_q[7:0];
        endcase
    end

    // The first RMW_WR cycle is an idle bus cycle so the memory sees Mem_En drop between read and write.
    assign access_w = (state_q == READ) || (state_q == RMW_RD) || (state_q == WRITE) ||
                      ((state_q == RMW_WR) && !gap_q);

    always_comb begin
        state_d  = state_q;
        byte_d   = byte_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        merged_d = merged_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        case (state_q)
            IDLE: begin
                if (Req_Valid && Req_Ready) begin
                    byte_d  = Req_Byte;
                    addr_d  = Req_Addr;
                    wdata_d = Req_Wdata;
                    cnt_d   = '0;
                    if (!Req_Byte && (Req_Addr[1:0] != 2'b00)) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end else if (!Req_Write) begin
                        state_d = READ;
                    end else if (Req_Byte) begin
                        state_d = RMW_RD;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            READ, RMW_RD, RMW_WR, WRITE: begin
                if (!access_w) begin
                    gap_d = 1'b0;
                end else if (Mem_Ack) begin
                    if (state_q == RMW_RD) begin
                        merged_d = merge_w;
                        gap_d    = 1'b1;
                        cnt_d    = '0;
                        state_d  = RMW_WR;
                    end else begin
                        err_d   = 1'b0;
                        rdata_d = (state_q == READ) ? Load_Data : 32'h0;
                        state_d = RESP;
                    end
                end else if (cnt_q == 8'(MAX_WAIT - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    gap_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign Req_Ready   = rst_n && (state_q == IDLE);
    assign Resp_Valid  = (state_q == RESP);
    assign Resp_Error  = err_q;
    assign Resp_Rdata  = rdata_q;
    assign Mem_En      = access_w;
    assign Mem_We      = access_w && ((state_q == RMW_WR) || (state_q == WRITE));
    assign Mem_Addr    = access_w ? {addr_q[31:2], 2'b00} : 32'h0;
    assign Mem_Wdata   = !Mem_We ? 32'h0 : ((state_q == RMW_WR) ? merged_q : wdata_q);
    assign Load_Select = (state_q != IDLE) && byte_q;
    assign Offset      = (state_q != IDLE) ? addr_q[1:0] : 2'b00;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        Req_Valid;
    logic        Req_Ready;
    logic        Req_Write;
    logic        Req_Byte;
    logic [31:0] Req_Addr;
    logic [31:0] Req_Wdata;
    logic        Resp_Valid;
    logic        Resp_Error;
    logic [31:0] Resp_Rdata;
    logic        Mem_En;
    logic        Mem_We;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_Wdata;
    logic [31:0] Mem_Rdata;
    logic        Mem_Ack;
    logic        Load_Select;
    logic [1:0]  Offset;
    logic [31:0] Load_Data;
    logic [31:0] shifted;

    int tests_run;
    int tests_failed;

    mem_access_ctrl #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Write(Req_Write),
        .Req_Byte(Req_Byte), .Req_Addr(Req_Addr), .Req_Wdata(Req_Wdata),
        .Resp_Valid(Resp_Valid), .Resp_Error(Resp_Error), .Resp_Rdata(Resp_Rdata),
        .Mem_En(Mem_En), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata),
        .Mem_Rdata(Mem_Rdata), .Mem_Ack(Mem_Ack),
        .Load_Select(Load_Select), .Offset(Offset), .Load_Data(Load_Data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External load-extraction block: zero-extended byte lane or full word.
    always_comb begin
        shifted   = Mem_Rdata >> {Offset, 3'b000};
        Load_Data = Load_Select ? {24'h0, shifted[7:0]} : Mem_Rdata;
    end

    // Presents a request for one cycle; returns at the negedge of the first cycle after accept.
    task automatic drive_req(input logic w, input logic b, input logic [31:0] a, input logic [31:0] d);
        Req_Valid = 1'b1; Req_Write = w; Req_Byte = b; Req_Addr = a; Req_Wdata = d;
        @(negedge clk);
        Req_Valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++; if (Req_Ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b expected 0", Req_Ready); end
        tests_run++; if ({Mem_En, Resp_Valid, Load_Select, Resp_Rdata} !== 35'h0) begin tests_failed++; $display("FAIL reset_outputs: got en=%b rv=%b ls=%b rd=%h expected all 0", Mem_En, Resp_Valid, Load_Select, Resp_Rdata); end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++; if (Req_Ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_ready: got %b expected 1", Req_Ready); end
    endtask

    task automatic test_word_load_late_ack();
        Mem_Rdata = 32'hDEADBEEF;
        drive_req(1'b0, 1'b0, 32'h100, 32'h0);
        tests_run++; if ({Mem_En, Mem_We, Mem_Addr} !== {2'b10, 32'h100}) begin tests_failed++; $display("FAIL wl_access: got en=%b we=%b addr=%h expected 1 0 00000100", Mem_En, Mem_We, Mem_Addr); end
        @(negedge clk);
        @(negedge clk);
        Mem_Ack = 1'b1;
        @(negedge clk);
        Mem_Ack = 1'b0;
        tests_run++; if ({Resp_Valid, Resp_Error, Mem_En} !== 3'b100) begin tests_failed++; $display("FAIL wl_resp_t4: got rv=%b err=%b en=%b expected 1 0 0", Resp_Valid, Resp_Error, Mem_En); end
        tests_run++; if (Resp_Rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL wl_rdata: got %h expected deadbeef", Resp_Rdata); end
        @(negedge clk);
        tests_run++; if ({Resp_Valid, Req_Ready, Resp_Rdata} !== {2'b01, 32'hDEADBEEF}) begin tests_failed++; $display("FAIL wl_hold: got rv=%b rdy=%b rd=%h expected 0 1 deadbeef", Resp_Valid, Req_Ready, Resp_Rdata); end
    endtask

    task automatic test_misaligned();
        drive_req(1'b0, 1'b0, 32'h102, 32'h0);
        tests_run++; if ({Resp_Valid, Resp_Error, Mem_En, Resp_Rdata} !== {3'b110, 32'h0}) begin tests_failed++; $display("FAIL mis_resp: got rv=%b err=%b en=%b rd=%h expected 1 1 0 0", Resp_Valid, Resp_Error, Mem_En, Resp_Rdata); end
        @(negedge clk);
        tests_run++; if ({Resp_Valid, Mem_En, Req_Ready} !== 3'b001) begin tests_failed++; $display("FAIL mis_after: got rv=%b en=%b rdy=%b expected 0 0 1", Resp_Valid, Mem_En, Req_Ready); end
    endtask

    task automatic test_byte_load();
        Mem_Rdata = 32'hA1B2C3D4;
        drive_req(1'b0, 1'b1, 32'h103, 32'h0);
        Mem_Ack = 1'b1;
        tests_run++; if ({Load_Select, Offset, Mem_En, Mem_Addr} !== {4'b1111, 32'h100}) begin tests_failed++; $display("FAIL bl_lane: got ls=%b off=%0d en=%b addr=%h expected 1 3 1 00000100", Load_Select, Offset, Mem_En, Mem_Addr); end
        @(negedge clk);
        Mem_Ack = 1'b0;
        tests_run++; if ({Resp_Valid, Resp_Error, Resp_Rdata} !== {2'b10, 32'h000000A1}) begin tests_failed++; $display("FAIL bl_resp: got rv=%b err=%b rd=%h expected 1 0 000000a1", Resp_Valid, Resp_Error, Resp_Rdata); end
        @(negedge clk);
        tests_run++; if ({Load_Select, Offset} !== 3'b000) begin tests_failed++; $display("FAIL bl_idle_lane: got ls=%b off=%0d expected 0 0", Load_Select, Offset); end
    endtask

    task automatic test_timeout();
        int en_cycles;
        bit seen;
        en_cycles = 0;
        seen = 1'b0;
        Mem_Rdata = 32'h99999999;
        drive_req(1'b0, 1'b0, 32'h300, 32'h0);
        for (int i = 0; i < 20; i++) begin
            if (Resp_Valid) begin seen = 1'b1; break; end
            if (Mem_En) en_cycles++;
            @(negedge clk);
        end
        tests_run++; if (!seen) begin tests_failed++; $display("FAIL to_resp_seen: got no Resp_Valid in 20 cycles expected one"); end
        tests_run++; if (en_cycles !== 4) begin tests_failed++; $display("FAIL to_en_cycles: got %0d expected 4", en_cycles); end
        tests_run++; if ({Resp_Error, Resp_Rdata} !== {1'b1, 32'h0}) begin tests_failed++; $display("FAIL to_error: got err=%b rd=%h expected 1 0", Resp_Error, Resp_Rdata); end
        @(negedge clk);
        Mem_Rdata = 32'h12345678;
        drive_req(1'b0, 1'b0, 32'h400, 32'h0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        tests_run++; if (Mem_En !== 1'b1) begin tests_failed++; $display("FAIL to_en_4th: got %b expected 1", Mem_En); end
        Mem_Ack = 1'b1;
        @(negedge clk);
        Mem_Ack = 1'b0;
        tests_run++; if ({Resp_Valid, Resp_Error, Resp_Rdata} !== {2'b10, 32'h12345678}) begin tests_failed++; $display("FAIL to_ack_wins: got rv=%b err=%b rd=%h expected 1 0 12345678", Resp_Valid, Resp_Error, Resp_Rdata); end
        @(negedge clk);
    endtask

    task automatic test_byte_store();
        Mem_Rdata = 32'h11223344;
        drive_req(1'b1, 1'b1, 32'h201, 32'hFFFFFF55);
        Mem_Ack = 1'b1;
        tests_run++; if ({Mem_En, Mem_We, Mem_Addr} !== {2'b10, 32'h200}) begin tests_failed++; $display("FAIL bs_rd: got en=%b we=%b addr=%h expected 1 0 00000200", Mem_En, Mem_We, Mem_Addr); end
        @(negedge clk);
        Mem_Ack = 1'b0;
        tests_run++; if (Mem_En !== 1'b0) begin tests_failed++; $display("FAIL bs_gap: got en=%b expected 0", Mem_En); end
        @(negedge clk);
        Mem_Rdata = 32'h0;
        tests_run++; if ({Mem_En, Mem_We, Mem_Addr, Mem_Wdata} !== {2'b11, 32'h200, 32'h11225544}) begin tests_failed++; $display("FAIL bs_wr: got en=%b we=%b addr=%h wd=%h expected 1 1 00000200 11225544", Mem_En, Mem_We, Mem_Addr, Mem_Wdata); end
        Mem_Ack = 1'b1;
        @(negedge clk);
        Mem_Ack = 1'b0;
        tests_run++; if ({Resp_Valid, Resp_Error, Resp_Rdata} !== {2'b10, 32'h0}) begin tests_failed++; $display("FAIL bs_resp: got rv=%b err=%b rd=%h expected 1 0 0", Resp_Valid, Resp_Error, Resp_Rdata); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        drive_req(1'b1, 1'b0, 32'h500, 32'hCAFEF00D);
        Mem_Ack = 1'b1;
        tests_run++; if ({Mem_En, Mem_We, Mem_Wdata} !== {2'b11, 32'hCAFEF00D}) begin tests_failed++; $display("FAIL b2b_write: got en=%b we=%b wd=%h expected 1 1 cafef00d", Mem_En, Mem_We, Mem_Wdata); end
        @(negedge clk);
        Mem_Ack = 1'b0;
        tests_run++; if ({Resp_Valid, Req_Ready} !== 2'b10) begin tests_failed++; $display("FAIL b2b_resp: got rv=%b rdy=%b expected 1 0", Resp_Valid, Req_Ready); end
        Req_Valid = 1'b1; Req_Write = 1'b0; Req_Byte = 1'b0; Req_Addr = 32'h600; Mem_Rdata = 32'h0BADF00D;
        @(negedge clk);
        tests_run++; if ({Req_Ready, Mem_En} !== 2'b10) begin tests_failed++; $display("FAIL b2b_no_accept_in_resp: got rdy=%b en=%b expected 1 0", Req_Ready, Mem_En); end
        @(negedge clk);
        Req_Valid = 1'b0;
        Mem_Ack = 1'b1;
        tests_run++; if ({Mem_En, Mem_Addr} !== {1'b1, 32'h600}) begin tests_failed++; $display("FAIL b2b_second: got en=%b addr=%h expected 1 00000600", Mem_En, Mem_Addr); end
        @(negedge clk);
        Mem_Ack = 1'b0;
        tests_run++; if ({Resp_Valid, Resp_Rdata} !== {1'b1, 32'h0BADF00D}) begin tests_failed++; $display("FAIL b2b_second_resp: got rv=%b rd=%h expected 1 0badf00d", Resp_Valid, Resp_Rdata); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        bit resp_seen;
        resp_seen = 1'b0;
        Mem_Rdata = 32'h01020304;
        drive_req(1'b1, 1'b1, 32'h601, 32'h77);
        Mem_Ack = 1'b1;
        @(negedge clk);
        Mem_Ack = 1'b0;
        @(negedge clk);
        tests_run++; if ({Mem_En, Mem_We} !== 2'b11) begin tests_failed++; $display("FAIL rst_mid_in_wr: got en=%b we=%b expected 1 1", Mem_En, Mem_We); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if ({Mem_En, Req_Ready, Mem_We} !== 3'b000) begin tests_failed++; $display("FAIL rst_mid_async: got en=%b rdy=%b we=%b expected 0 0 0", Mem_En, Req_Ready, Mem_We); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (Resp_Valid) resp_seen = 1'b1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (Resp_Valid) resp_seen = 1'b1;
        tests_run++; if (resp_seen !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_no_resp: got Resp_Valid=1 expected none"); end
        tests_run++; if ({Req_Ready, Mem_En} !== 2'b10) begin tests_failed++; $display("FAIL rst_mid_release: got rdy=%b en=%b expected 1 0", Req_Ready, Mem_En); end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        Req_Valid = 1'b0; Req_Write = 1'b0; Req_Byte = 1'b0;
        Req_Addr = 32'h0; Req_Wdata = 32'h0;
        Mem_Rdata = 32'h0; Mem_Ack = 1'b0;
        test_reset();
        test_word_load_late_ack();
        test_misaligned();
        test_byte_load();
        test_timeout();
        test_byte_store();
        test_back_to_back();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
